// File: rtl/crc_buffer_engine_if.sv
// Register-bus bundle between a host and the CRC buffer engine.
// Latency: n/a (wires only); read data arrives one clock after srd.
// Backpressure: none; the host polls STATE or watches busy.
interface crc_buffer_engine_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic        busy;

  modport slave (
    input  saddress, srd, swr, sdata_in,
    output sdata_out, busy
  );

  modport master (
    output saddress, srd, swr, sdata_in,
    input  sdata_out, busy
  );
endinterface

// File: rtl/crc_buffer_engine.sv
// Byte buffer with a register map; GET runs a reflected CRC-32C/CRC-32 over the stored bytes.
// Latency: reads 1 clk; GET takes COUNT clks in BUSY (1 byte/clk), empty GET is READY next clk.
// Backpressure: none; CTRL/DATA/CONFIG writes are dropped while BUSY, reads are always served.
module crc_buffer_engine #(
  parameter int          DEPTH = 250,
  parameter logic [15:0] BASE  = 16'h0640
) (
  input  logic               clk,
  input  logic               reset,
  crc_buffer_engine_if.slave bus
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]    POLY_C  = 32'h82F63B78;
  localparam logic [31:0]    POLY_I  = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_ACCEPT = 3'd1,
    S_FULL   = 3'd2,
    S_READY  = 3'd3,
    S_ERROR  = 3'd4,
    S_BUSY   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   result_q, result_d;
  logic [31:0]   data_q, data_d;
  logic          mode_q, mode_d;
  logic          crc_mode_q, crc_mode_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          swr_q;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          mem_we;
  logic          wr_edge;
  logic [31:0]   crc_next;

  logic hit_data, hit_state, hit_result, hit_ctrl, hit_cfg, hit_count;

  assign wr_edge    = bus.swr & ~swr_q;
  assign hit_data   = (bus.saddress == BASE);
  assign hit_state  = (bus.saddress == BASE + 16'h08);
  assign hit_result = (bus.saddress == BASE + 16'h10);
  assign hit_ctrl   = (bus.saddress == BASE + 16'h18);
  assign hit_cfg    = (bus.saddress == BASE + 16'h20);
  assign hit_count  = (bus.saddress == BASE + 16'h28);

  assign bus.sdata_out = rdata_q;
  assign bus.busy      = (state_q == S_BUSY);

  // One reflected CRC byte step: fold the byte in, then eight LSB-first shifts.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b,
                                           input logic ieee);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ (ieee ? POLY_I : POLY_C)) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state: BUSY walks the buffer; otherwise act on a fresh swr edge; reads see pre-write values.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    crc_d      = crc_q;
    result_d   = result_q;
    data_d     = data_q;
    mode_d     = mode_q;
    crc_mode_d = crc_mode_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    crc_next   = crc_byte(crc_q, mem[idx_q[AW-1:0]], crc_mode_q);

    if (state_q == S_BUSY) begin
      crc_d = crc_next;
      if (idx_q == count_q - CW'(1)) begin
        state_d  = S_READY;
        result_d = ~crc_next;
      end else begin
        idx_d = idx_q + CW'(1);
      end
    end else if (wr_edge) begin
      if (hit_data) data_d = bus.sdata_in;
      if (hit_cfg)  mode_d = bus.sdata_in[0];
      if (hit_ctrl) begin
        case (bus.sdata_in)
          32'd1: begin
            if (state_q inside {S_ACCEPT, S_FULL, S_READY}) begin
              // A full buffer can also sit in READY after a GET, so test COUNT too.
              if (data_q > 32'hFF || count_q == DEPTH_C) begin
                state_d = S_ERROR;
              end else begin
                mem_we   = 1'b1;
                count_d  = count_q + CW'(1);
                result_d = 32'h0;
                state_d  = (count_q + CW'(1) == DEPTH_C) ? S_FULL : S_ACCEPT;
              end
            end
          end
          32'd2: begin
            if (state_q inside {S_ACCEPT, S_FULL, S_READY}) begin
              if (count_q == '0) begin
                state_d  = S_READY;
                result_d = 32'h0;
              end else begin
                state_d    = S_BUSY;
                idx_d      = '0;
                crc_d      = 32'hFFFF_FFFF;
                crc_mode_d = mode_q;
              end
            end
          end
          32'd3: begin
            state_d  = S_ACCEPT;
            count_d  = '0;
            result_d = 32'h0;
          end
          default: ;
        endcase
      end
    end

    if (bus.srd) begin
      if      (hit_data)   rdata_d = data_q;
      else if (hit_state)  rdata_d = {29'h0, state_q};
      else if (hit_result) rdata_d = result_q;
      else if (hit_cfg)    rdata_d = {31'h0, mode_q};
      else if (hit_count)  rdata_d = {{(32-CW){1'b0}}, count_q};
      else                 rdata_d = 32'h0;
    end
  end

  // State and register update; reset wins over any bus access and aborts BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ACCEPT;
      count_q    <= '0;
      idx_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      result_q   <= 32'h0;
      data_q     <= 32'h0;
      mode_q     <= 1'b0;
      crc_mode_q <= 1'b0;
      rdata_q    <= 32'h0;
      swr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      result_q   <= result_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      crc_mode_q <= crc_mode_d;
      rdata_q    <= rdata_d;
      swr_q      <= bus.swr;
    end
  end

  // Byte store; contents are not reset, COUNT alone defines what is valid.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[count_q[AW-1:0]] <= data_q[7:0];
  end

endmodule

// File: tb/tb_crc_buffer_engine.sv
// Randomised and directed bench with a queue-based reference model and read scoreboard.
// Latency: expects read data and busy one clock after the strobe edge.
// Backpressure: none; GET completion is awaited by bounded STATE polling.
module tb_crc_buffer_engine;

  localparam int          DEPTH    = 250;
  localparam logic [15:0] BASE     = 16'h0640;
  localparam logic [15:0] A_DATA   = BASE;
  localparam logic [15:0] A_STATE  = BASE + 16'h08;
  localparam logic [15:0] A_RESULT = BASE + 16'h10;
  localparam logic [15:0] A_CTRL   = BASE + 16'h18;
  localparam logic [15:0] A_CFG    = BASE + 16'h20;
  localparam logic [15:0] A_COUNT  = BASE + 16'h28;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crc_buffer_engine_if bus();

  crc_buffer_engine #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] dat;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: buffer as a byte queue, state as the architectural code.
  int            m_state;
  logic [31:0]   m_data;
  logic [31:0]   m_result;
  bit            m_mode;
  bit            m_gmode;
  bit            m_prev_swr;
  int            m_left;
  byte unsigned  m_buf[$];

  function automatic logic [31:0] ref_crc(input bit ieee);
    logic [31:0] c;
    logic [31:0] poly;
    poly = ieee ? 32'hEDB88320 : 32'h82F63B78;
    c = 32'hFFFF_FFFF;
    foreach (m_buf[i]) begin
      c = c ^ {24'h0, m_buf[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a == A_DATA)   return m_data;
    if (a == A_STATE)  return 32'(m_state);
    if (a == A_RESULT) return m_result;
    if (a == A_CFG)    return {31'h0, m_mode};
    if (a == A_COUNT)  return 32'(m_buf.size());
    return 32'h0;
  endfunction

  function automatic void model_step(input logic [15:0] a, input bit wr,
                                     input logic [31:0] d, input bit rst);
    bit edge_seen;
    if (rst) begin
      m_state = 1; m_data = 0; m_result = 0; m_mode = 0;
      m_buf.delete(); m_prev_swr = 0; m_left = 0;
      return;
    end
    edge_seen  = wr && !m_prev_swr;
    m_prev_swr = wr;
    if (m_state == 5) begin
      m_left--;
      if (m_left == 0) begin
        m_state  = 3;
        m_result = ref_crc(m_gmode);
      end
      return;
    end
    if (!edge_seen) return;
    if (a == A_DATA) m_data = d;
    else if (a == A_CFG) m_mode = d[0];
    else if (a == A_CTRL) begin
      if (d == 1 && m_state inside {1, 2, 3}) begin
        if (m_data > 255 || m_buf.size() == DEPTH) m_state = 4;
        else begin
          m_buf.push_back(m_data[7:0]);
          m_result = 0;
          m_state  = (m_buf.size() == DEPTH) ? 2 : 1;
        end
      end else if (d == 2 && m_state inside {1, 2, 3}) begin
        if (m_buf.size() == 0) begin
          m_state = 3; m_result = 0;
        end else begin
          m_state = 5; m_left = m_buf.size(); m_gmode = m_mode;
        end
      end else if (d == 3) begin
        m_state = 1; m_result = 0; m_buf.delete();
      end
    end
  endfunction

  // One bus cycle: drive at negedge, predict, and queue the expected read response.
  task automatic cyc(input logic [15:0] a, input bit rd, input bit wr, input logic [31:0] d,
                     input bit rst, input bit use_k, input logic [31:0] k, input string nm);
    logic [31:0] r;
    @(negedge clk);
    reset        = rst;
    bus.saddress = a;
    bus.srd      = rd;
    bus.swr      = wr;
    bus.sdata_in = d;
    r = rst ? 32'h0 : model_read(a);
    model_step(a, wr, d, rst);
    if (use_k) r = k;
    if (rd) sb.push_back('{nm, r, (m_state == 5)});
    @(posedge clk);
  endtask

  task automatic idle();
    cyc(16'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cyc(a, 1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0, "wr");
    idle();
  endtask

  task automatic rd(input logic [15:0] a, input string nm);
    cyc(a, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, nm);
  endtask

  task automatic rdk(input logic [15:0] a, input logic [31:0] k, input string nm);
    cyc(a, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, k, nm);
  endtask

  task automatic put(input logic [31:0] b);
    wr(A_DATA, b);
    wr(A_CTRL, 32'd1);
  endtask

  task automatic poll_ready();
    for (int i = 0; i < 2000 && m_state != 3; i++) rd(A_STATE, "poll_state");
  endtask

  // Monitor: every strobed read is compared one clock later against the queue head.
  initial begin
    logic seen;
    exp_t e;
    forever begin
      @(posedge clk);
      seen = (bus.srd === 1'b1);
      @(negedge clk);
      if (seen) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: sdata_out=%h with no prediction queued", bus.sdata_out);
        end else begin
          e = sb.pop_front();
          if (bus.sdata_out !== e.dat || bus.busy !== e.bsy) begin
            errors++;
            $display("FAIL %s: got sdata_out=%h busy=%b, want sdata_out=%h busy=%b",
                     e.name, bus.sdata_out, bus.busy, e.dat, e.bsy);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  logic [15:0] addr_tab [8];

  initial begin
    addr_tab[0] = A_DATA;  addr_tab[1] = A_STATE; addr_tab[2] = A_RESULT; addr_tab[3] = A_CTRL;
    addr_tab[4] = A_CFG;   addr_tab[5] = A_COUNT; addr_tab[6] = BASE + 16'h04; addr_tab[7] = 16'h0000;
    reset = 1'b1; bus.saddress = '0; bus.srd = 1'b0; bus.swr = 1'b0; bus.sdata_in = '0;

    // Reset values, including a read issued during reset.
    cyc(A_STATE, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, "rst0");
    cyc(A_STATE, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, "rst_read");
    rdk(A_STATE,  32'd1, "reset_state");
    rdk(A_COUNT,  32'd0, "reset_count");
    rdk(A_RESULT, 32'd0, "reset_result");
    rdk(A_DATA,   32'd0, "reset_data");
    rdk(A_CFG,    32'd0, "reset_config");
    wr(A_CTRL, 32'd2);
    rdk(A_CTRL,   32'd0, "ctrl_reads_zero");
    rdk(BASE + 16'h30, 32'd0, "unmapped_zero");
    wr(A_CTRL, 32'd3);

    // Two-byte CRC-32C and a repeated GET.
    put(32'hAC); put(32'hDC);
    wr(A_CTRL, 32'd2); poll_ready();
    rdk(A_RESULT, 32'h3827E236, "crc_acdc");
    wr(A_CTRL, 32'd2); poll_ready();
    rdk(A_RESULT, 32'h3827E236, "crc_acdc_again");

    // Commands, DATA and CONFIG writes are dropped while BUSY.
    wr(A_CTRL, 32'd3);
    for (int i = 0; i < 8; i++) put(32'h12);
    wr(A_CTRL, 32'd2);
    wr(A_CTRL, 32'd3);
    wr(A_CTRL, 32'd3);
    wr(A_DATA, 32'h77);
    cyc(A_CFG, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, "cfg_busy");
    poll_ready();
    rdk(A_RESULT, 32'hB2D007FC, "crc_8x12");
    rdk(A_CFG,    32'd0,  "cfg_ignored_busy");
    rdk(A_DATA,   32'h12, "data_ignored_busy");
    wr(A_CTRL, 32'd3);
    rdk(A_RESULT, 32'd0, "clr_result");
    rdk(A_STATE,  32'd1, "clr_state");

    // Polynomial selection.
    wr(A_CFG, 32'd0); put(32'h00); wr(A_CTRL, 32'd2); poll_ready();
    rdk(A_RESULT, 32'h527D5351, "crc32c_zero");
    wr(A_CTRL, 32'd3);
    wr(A_CFG, 32'd1); put(32'h00); wr(A_CTRL, 32'd2); poll_ready();
    rdk(A_RESULT, 32'hD202EF8D, "crc32_zero");

    // Capacity boundary.
    wr(A_CTRL, 32'd3);
    for (int i = 0; i < DEPTH - 1; i++) put($urandom_range(0, 255));
    rdk(A_STATE, 32'd1, "state_depth_m1");
    put($urandom_range(0, 255));
    rdk(A_STATE, 32'd2, "state_full");
    put(32'h33);
    rdk(A_STATE, 32'd4, "state_overflow");
    rdk(A_COUNT, 32'(DEPTH), "count_overflow");
    wr(A_CTRL, 32'd2);
    rdk(A_STATE, 32'd4, "get_in_error");

    // Out-of-range byte and empty GET.
    wr(A_CTRL, 32'd3);
    put(32'h100);
    rdk(A_STATE, 32'd4, "bad_byte_state");
    rdk(A_COUNT, 32'd0, "bad_byte_count");
    wr(A_CTRL, 32'd3);
    cyc(A_CTRL, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 32'h0, "get_empty");
    rdk(A_STATE,  32'd3, "empty_ready");
    rdk(A_RESULT, 32'd0, "empty_result");

    // Holding swr high acts only once.
    wr(A_CTRL, 32'd3);
    wr(A_DATA, 32'h5A);
    for (int i = 0; i < 3; i++) cyc(A_CTRL, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 32'h0, "hold");
    idle();
    rdk(A_COUNT, 32'd1, "swr_held_once");

    // Random bus traffic against the model.
    wr(A_CFG, $urandom);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      logic [31:0] d;
      a = addr_tab[$urandom_range(0, 7)];
      if (a == A_CTRL)      d = 32'($urandom_range(0, 4));
      else if (a == A_DATA) d = 32'($urandom_range(0, 300));
      else                  d = $urandom;
      cyc(a, bit'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), d, 1'b0, 1'b0, 32'h0, "random");
    end
    idle();
    wr(A_CTRL, 32'd3);

    // Reset aborts BUSY mid-operation.
    wr(A_CFG, 32'd1);
    for (int i = 0; i < 8; i++) put($urandom_range(0, 255));
    cyc(A_CTRL, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 32'h0, "get_then_reset");
    cyc(A_STATE, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, "reset_busy_read");
    rdk(A_STATE,  32'd1, "abort_state");
    rdk(A_COUNT,  32'd0, "abort_count");
    rdk(A_RESULT, 32'd0, "abort_result");
    rdk(A_CFG,    32'd0, "abort_config");
    idle(); idle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
